axis_uart_frame_rx: RTL

AXIS_UART_FRAME_RX -- requirements
Module: axis_uart_frame_rx

---
 rtl/axis_uart_frame_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/axis_uart_frame_rx.sv
// Frame decoder behind a UART byte stream: SYNC, LEN, payload, XOR checksum.
// Payload is buffered and replayed on an AXI-Stream master only once the checksum matches.
module axis_uart_frame_rx #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [2:0] dbg_state
);
  // Handshake rule on both ports: a byte moves only on a rising edge where
  // tvalid and tready are both high; tdata/tlast are held while tvalid waits.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_SEND    = 3'd4
  } state_e;

  localparam int             TW       = $clog2(TIMEOUT_CYCLES);
  localparam int             IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  state_e        state_q;
  logic [7:0]    len_q;
  logic [7:0]    wr_idx_q;
  logic [7:0]    rd_idx_q;
  logic [7:0]    chk_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    m_tdata_q;
  logic          m_tvalid_q;
  logic          m_tlast_q;
  logic          frame_ok_q;
  logic          frame_err_q;
  logic [1:0]    err_code_q;

  logic [7:0] buf_mem [MAX_LEN];

  logic s_acc;
  logic timed_state;
  logic timed_out;

  assign s_axis_tready = ~areset & (state_q != S_SEND);
  assign s_acc         = s_axis_tvalid & s_axis_tready;
  assign timed_state   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign timed_out     = timed_state && !s_acc && (tmo_q == TMO_LAST);

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign frame_ok      = frame_ok_q;
  assign frame_err     = frame_err_q;
  assign err_code      = err_code_q;
  assign dbg_state     = state_q;

  // Buffer is deliberately left out of reset; it is always rewritten before SEND reads it.
  always_ff @(posedge aclk) begin
    if (state_q == S_PAYLOAD && s_acc) begin
      buf_mem[wr_idx_q[IW-1:0]] <= s_axis_tdata;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      // Any accepted byte (including the one that enters a timed state) restarts the count.
      tmo_q <= (timed_state && !s_acc && !timed_out) ? tmo_q + 1'b1 : '0;

      if (timed_out) begin
        frame_err_q <= 1'b1;
        err_code_q  <= 2'd3;
        state_q     <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (s_acc && s_axis_tdata == SYNC_BYTE) state_q <= S_LEN;
          end
          S_LEN: begin
            if (s_acc) begin
              if (s_axis_tdata == 8'd0 || s_axis_tdata > MAX_LEN_B) begin
                frame_err_q <= 1'b1;
                err_code_q  <= 2'd1;
                state_q     <= S_IDLE;
              end else begin
                len_q    <= s_axis_tdata;
                chk_q    <= s_axis_tdata;
                wr_idx_q <= '0;
                state_q  <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (s_acc) begin
              chk_q    <= chk_q ^ s_axis_tdata;
              wr_idx_q <= wr_idx_q + 8'd1;
              if (wr_idx_q == len_q - 8'd1) state_q <= S_CHK;
            end
          end
          S_CHK: begin
            if (s_acc) begin
              if (s_axis_tdata == chk_q) begin
                frame_ok_q <= 1'b1;
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= buf_mem[0];
                m_tlast_q  <= (len_q == 8'd1);
                rd_idx_q   <= 8'd1;
                state_q    <= S_SEND;
              end else begin
                frame_err_q <= 1'b1;
                err_code_q  <= 2'd2;
                state_q     <= S_IDLE;
              end
            end
          end
          S_SEND: begin
            if (m_tvalid_q && m_axis_tready) begin
              if (m_tlast_q) begin
                m_tvalid_q <= 1'b0;
                m_tlast_q  <= 1'b0;
                state_q    <= S_IDLE;
              end else begin
                m_tdata_q <= buf_mem[rd_idx_q[IW-1:0]];
                m_tlast_q <= (rd_idx_q == len_q - 8'd1);
                rd_idx_q  <= rd_idx_q + 8'd1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
